ibex_bloom_unit: RTL and testbench

Bloom-filter responder for the custom-instruction port of the execute stage. It accepts insert, check and reset commands issued alongside the ALU with operands RS1/RS2. It hashes the key into a parameterised bit array over several cycles and returns a one-cycle completion pulse, plus a match flag for checks. Hashing runs for a fixed number of cycles regardless of data.

---
 rtl/ibex_bloom_unit_pkg.sv | 18 +
 rtl/ibex_bloom_unit_hash.sv | 17 +
 rtl/ibex_bloom_unit.sv | 133 +++++++++++++
 tb/tb_ibex_bloom_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ibex_bloom_unit_pkg.sv
// Shared types and constants for the Bloom-filter custom-instruction unit.
package ibex_bloom_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HASH  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } bloom_state_e;

    localparam int unsigned HASH_SEL_W = 2;

    // Entry 0 is the rightmost word.
    localparam logic [3:0][31:0] BLOOM_SEED = {
        32'h27D4EB2F, 32'hC2B2AE3D, 32'h85EBCA77, 32'h9E3779B1
    };

endpackage

// File: rtl/ibex_bloom_unit_hash.sv
// Multiplicative hash: top IDX_W bits of the low 32 bits of key * seed[j].
module ibex_bloom_hash
    import ibex_bloom_unit_pkg::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic [31:0]           key_i,
    input  logic [HASH_SEL_W-1:0] j_i,
    output logic [IDX_W-1:0]      h_o
);

    logic [31:0] prod;

    assign prod = key_i * BLOOM_SEED[j_i];
    assign h_o  = prod[31 -: IDX_W];

endmodule

// File: rtl/ibex_bloom_unit.sv
// Bloom-filter responder for the custom-instruction port.
// IBEX_BLOOM_FAST_CLEAR_EN: clear the whole array in one edge instead of word-serially.
module ibex_bloom_unit
    import ibex_bloom_unit_pkg::*;
#(
    parameter int unsigned FILTER_BITS = 256,
    parameter int unsigned NUM_HASH    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        custom_en_i,
    input  logic [31:0] custom_in_RS1_i,
    input  logic [31:0] custom_in_RS2_i,
    input  logic        insert_bloom_i,
    input  logic        check_bloom_i,
    input  logic        reset_bloom_i,
    output logic        custom_valid_o,
    output logic        match_bloom_o,
    output logic        busy_o
);

    localparam int unsigned IDX_W = $clog2(FILTER_BITS);
`ifndef IBEX_BLOOM_FAST_CLEAR_EN
    localparam int unsigned WORDS  = FILTER_BITS / 32;
    localparam int unsigned WORD_W = $clog2(WORDS);
`endif

    bloom_state_e           state_q, state_d;
    logic [HASH_SEL_W-1:0]  j_q, j_d;
    logic [31:0]            key_q, key_d;
    logic                   is_check_q, is_check_d;
    logic                   acc_q, acc_d;
    logic                   match_q, match_d;
    logic [FILTER_BITS-1:0] arr_q, arr_d;
`ifndef IBEX_BLOOM_FAST_CLEAR_EN
    logic [WORD_W-1:0]      w_q, w_d;
`endif
    logic [IDX_W-1:0]       h;

    // One hash instance, stepped through the seeds by j.
    ibex_bloom_hash #(.IDX_W(IDX_W)) u_hash (
        .key_i (key_q),
        .j_i   (j_q),
        .h_o   (h)
    );

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        key_d      = key_q;
        is_check_d = is_check_q;
        acc_d      = acc_q;
        match_d    = match_q;
        arr_d      = arr_q;
`ifndef IBEX_BLOOM_FAST_CLEAR_EN
        w_d        = w_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (custom_en_i && (reset_bloom_i || insert_bloom_i || check_bloom_i)) begin
                    key_d      = custom_in_RS1_i ^ custom_in_RS2_i;
                    j_d        = '0;
                    acc_d      = 1'b1;
                    is_check_d = !reset_bloom_i && !insert_bloom_i;
                    if (reset_bloom_i) begin
`ifdef IBEX_BLOOM_FAST_CLEAR_EN
                        arr_d   = '0;
                        state_d = DONE;
`else
                        w_d     = '0;
                        state_d = CLEAR;
`endif
                    end else begin
                        state_d = HASH;
                    end
                end
            end
            HASH: begin
                if (is_check_q) acc_d = acc_q & arr_q[h];
                else            arr_d[h] = 1'b1;
                // Always run all hashes so latency never depends on the data.
                if (j_q == HASH_SEL_W'(NUM_HASH - 1)) begin
                    state_d = DONE;
                    if (is_check_q) match_d = acc_d;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            CLEAR: begin
`ifdef IBEX_BLOOM_FAST_CLEAR_EN
                state_d = IDLE;
`else
                arr_d[{w_q, 5'd0} +: 32] = '0;
                if (w_q == WORD_W'(WORDS - 1)) state_d = DONE;
                else                           w_d = w_q + 1'b1;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            j_q        <= '0;
            key_q      <= '0;
            is_check_q <= 1'b0;
            acc_q      <= 1'b0;
            match_q    <= 1'b0;
            arr_q      <= '0;
`ifndef IBEX_BLOOM_FAST_CLEAR_EN
            w_q        <= '0;
`endif
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            key_q      <= key_d;
            is_check_q <= is_check_d;
            acc_q      <= acc_d;
            match_q    <= match_d;
            arr_q      <= arr_d;
`ifndef IBEX_BLOOM_FAST_CLEAR_EN
            w_q        <= w_d;
`endif
        end
    end

    assign custom_valid_o = (state_q == DONE);
    assign match_bloom_o  = match_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_bloom_unit.sv
// Directed scoreboard bench for ibex_bloom_unit (FILTER_BITS=256, NUM_HASH=3).
module tb_ibex_bloom_unit;

    logic        clk, rst;
    logic        en, ins, chkq, clr;
    logic [31:0] rs1, rs2;
    logic        valid, match, busy;

    typedef struct { logic m; int c; } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int n_cmp = 0, n_err = 0, n_push = 0, n_pulse = 0;

`ifdef IBEX_BLOOM_FAST_CLEAR_EN
    localparam int CLR_LAT = 0;
`else
    localparam int CLR_LAT = 8;
`endif

    ibex_bloom_unit #(.FILTER_BITS(256), .NUM_HASH(3)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .custom_en_i     (en),
        .custom_in_RS1_i (rs1),
        .custom_in_RS2_i (rs2),
        .insert_bloom_i  (ins),
        .check_bloom_i   (chkq),
        .reset_bloom_i   (clr),
        .custom_valid_o  (valid),
        .match_bloom_o   (match),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && valid) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("match", match, e.m);
                chk("latency_cycle", cyc, e.c);
            end
        end
    end

    // lat = edges from acceptance to the edge that enters DONE.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic i, input logic c, input logic r,
                         input logic exp_m, input int lat, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin @(negedge clk); n++; end
        if (busy) chk("idle_wait_timeout", busy, 0);
        if (push) begin
            exp_q.push_back('{exp_m, cyc + 1 + lat});
            n_push++;
        end
        rs1 = a; rs2 = b; ins = i; chkq = c; clr = r; en = 1'b1;
        @(negedge clk);
        en = 1'b0; ins = 1'b0; chkq = 1'b0; clr = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin @(negedge clk); n++; end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    logic [255:0] exp_arr;

    initial begin
        rst = 1'b1; en = 0; ins = 0; chkq = 0; clr = 0; rs1 = 0; rs2 = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_valid", valid, 0);
        chk("reset_match", match, 0);
        chk("reset_array", dut.arr_q, 0);
        rst = 1'b0;

        // Empty filter: check key 1 misses.
        issue(32'd1, 32'd0, 0, 1, 0, 1'b0, 3, 1);
        drain();

        // Insert key 1 -> bits 0x9E, 0x85, 0xC2.
        issue(32'd1, 32'd0, 1, 0, 0, 1'b0, 3, 1);
        drain();
        exp_arr = '0;
        exp_arr[8'h9E] = 1'b1; exp_arr[8'h85] = 1'b1; exp_arr[8'hC2] = 1'b1;
        chk("insert_key1_bits", dut.arr_q, exp_arr);
        issue(32'd1, 32'd0, 0, 1, 0, 1'b1, 3, 1);

        // Key 0 maps every hash to bit 0.
        issue(32'd0, 32'd0, 1, 0, 0, 1'b1, 3, 1);
        issue(32'd5, 32'd5, 0, 1, 0, 1'b1, 3, 1);
        // Key 2 -> 0x3C, 0x0B, 0x85: only 0x85 set.
        issue(32'd2, 32'd0, 0, 1, 0, 1'b0, 3, 1);
        // Insert again is idempotent.
        issue(32'd1, 32'd0, 1, 0, 0, 1'b0, 3, 1);
        drain();
        exp_arr[0] = 1'b1;
        chk("idempotent_bits", dut.arr_q, exp_arr);

        // Clear command.
        issue(32'd0, 32'd0, 0, 0, 1, 1'b0, CLR_LAT, 1);
        drain();
        chk("clear_array", dut.arr_q, 0);
        issue(32'd1, 32'd0, 0, 1, 0, 1'b0, 3, 1);

        // No qualifier -> ignored.
        drain();
        @(negedge clk);
        rs1 = 32'd1; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("no_qual_ignored", busy, 0);

        // Held request with operand change after acceptance.
        issue(32'd1, 32'd0, 1, 0, 0, 1'b0, 3, 1);
        drain();
        exp_q.push_back('{1'b1, cyc + 1 + 3});
        n_push++;
        rs1 = 32'd1; rs2 = 32'd0; chkq = 1'b1; en = 1'b1;
        @(negedge clk);
        rs1 = 32'd2;
        repeat (3) @(negedge clk);
        en = 1'b0; chkq = 1'b0;
        @(negedge clk);
        chk("held_no_reaccept", busy, 0);

        // All qualifiers: reset wins.
        issue(32'd1, 32'd0, 1, 1, 1, 1'b1, CLR_LAT, 1);
        drain();
        chk("priority_reset_array", dut.arr_q, 0);
        // Insert+check: insert wins, match untouched.
        issue(32'd1, 32'd0, 1, 1, 0, 1'b1, 3, 1);
        issue(32'd1, 32'd0, 0, 1, 0, 1'b1, 3, 1);
        drain();

        // Reset pulse during HASH of an insert: no completion.
        issue(32'd2, 32'd0, 1, 0, 0, 1'b0, 3, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_busy_after", busy, 0);
        chk("abort_array", dut.arr_q, 0);
        chk("abort_match", match, 0);

        chk("pulse_count", n_pulse, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
